pll_reset_sequencer: RTL and testbench

- Parametrised reset/lock sequencer for PLL-derived clock domains (PLLE2_ADV-class primitive, N CLKOUT channels).
- Drives PLL RST, qualifies LOCKED for a programmable stable time, then releases per-channel resets in fixed index order.
- On loss of lock it re-asserts all channel resets at once and restarts.
- Sits between top-level reset input and the FDCE-based logic clocked by each CLKOUTn; it is the successor to hand-wiring RST/LOCKED per test design.

---
 rtl/pll_reset_sequencer_pkg.sv | 22 ++
 rtl/pll_reset_sequencer_sync.sv | 28 ++
 rtl/pll_reset_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reset_sequencer_pkg.sv
// rtl/pll_reset_sequencer_pkg.sv - shared types and width helpers for the PLL reset sequencer
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN
  } seq_state_e;

  localparam int LOSS_CNT_W = 8;

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync.sv
// rtl/pll_reset_sequencer_sync.sv - multi-flop synchroniser for asynchronous status inputs
module pll_seq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL RST/LOCKED sequencer with ordered per-channel reset release
// Optional WAIT_LOCK timeout enabled by defining PLL_RESET_SEQUENCER_LOCK_TIMEOUT_EN.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_CH              = 3,
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 8,
  parameter int LOCK_STABLE_CYCLES  = 16,
  parameter int CH_GAP_CYCLES       = 4,
  parameter int LOCK_TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  cpu_reset_n,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic [NUM_CH-1:0]     ch_rst,
  output logic                  all_ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
  output logic                  timeout_flag
);

  if (NUM_CH < 1 || NUM_CH > 8 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      PLL_RST_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 || CH_GAP_CYCLES < 1 ||
      LOCK_TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("pll_reset_sequencer: parameter out of range");
  end

  localparam int REL_SPAN = (NUM_CH - 1) * CH_GAP_CYCLES;
  localparam int CNT_MAX  = max_int(max_int(PLL_RST_CYCLES, LOCK_STABLE_CYCLES), REL_SPAN + 1);
  localparam int CNT_W    = cnt_width(CNT_MAX);
  // The WAIT_LOCK cycle that first sees locked_s counts as the first qualified cycle.
  localparam int STABLE_END = (LOCK_STABLE_CYCLES >= 2) ? LOCK_STABLE_CYCLES - 2 : 0;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_END);
  localparam logic [CNT_W-1:0] REL_LAST    = CNT_W'(REL_SPAN);

  seq_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    pll_rst_q, pll_rst_d;
  logic [NUM_CH-1:0]       ch_rst_q, ch_rst_d;
  logic                    all_ready_q, all_ready_d;
  logic [LOSS_CNT_W-1:0]   loss_q, loss_d;
  logic                    locked_s;
  logic                    lost;
  logic                    lock_timeout;

  pll_seq_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (cpu_reset_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

`ifdef PLL_RESET_SEQUENCER_LOCK_TIMEOUT_EN
  localparam int TO_W = cnt_width(LOCK_TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;

  assign lock_timeout = (to_cnt_q == TO_LAST);

  always_comb begin
    to_cnt_d  = '0;
    timeout_d = timeout_q;
    if (state_q == WAIT_LOCK && state_d == WAIT_LOCK) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
    if (state_q == WAIT_LOCK && state_d == PLL_RST) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_flag = timeout_q;
`else
  assign lock_timeout = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ch_rst_d    = ch_rst_q;
    loss_d      = loss_q;
    lost        = 1'b0;
    cnt_inc     = cnt_q + 1'b1;

    unique case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_LOCK: begin
        cnt_d = '0;
        if (locked_s) begin
          state_d = STABLE;
        end else if (lock_timeout) begin
          state_d = PLL_RST;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d     = RELEASE;
          cnt_d       = '0;
          ch_rst_d[0] = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RELEASE: begin
        if (!locked_s) begin
          lost = 1'b1;
        end else begin
          // cnt_q counts cycles since ch_rst[0] was released.
          for (int i = 1; i < NUM_CH; i++) begin
            if (cnt_inc == CNT_W'(i * CH_GAP_CYCLES)) begin
              ch_rst_d[i] = 1'b0;
            end
          end
          if (cnt_q == REL_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      RUN: begin
        if (!locked_s) begin
          lost = 1'b1;
        end
      end
      default: begin
        state_d = PLL_RST;
        cnt_d   = '0;
        ch_rst_d = '1;
      end
    endcase

    if (lost) begin
      state_d  = PLL_RST;
      cnt_d    = '0;
      ch_rst_d = '1;
      loss_d   = (loss_q == '1) ? loss_q : loss_q + 1'b1;
    end

    pll_rst_d   = (state_d == PLL_RST);
    all_ready_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      pll_rst_q   <= 1'b1;
      ch_rst_q    <= '1;
      all_ready_q <= 1'b0;
      loss_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_rst_q   <= pll_rst_d;
      ch_rst_q    <= ch_rst_d;
      all_ready_q <= all_ready_d;
      loss_q      <= loss_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign ch_rst        = ch_rst_q;
  assign all_ready     = all_ready_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - scoreboard bench for pll_reset_sequencer at default parameters
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       cpu_reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic [2:0] ch_rst;
  logic       all_ready;
  logic [7:0] lock_loss_cnt;
  logic       timeout_flag;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .NUM_CH              (3),
    .SYNC_STAGES         (2),
    .PLL_RST_CYCLES      (8),
    .LOCK_STABLE_CYCLES  (16),
    .CH_GAP_CYCLES       (4),
    .LOCK_TIMEOUT_CYCLES (1024)
  ) dut (
    .clk           (clk),
    .cpu_reset_n   (cpu_reset_n),
    .pll_locked    (pll_locked),
    .pll_rst       (pll_rst),
    .ch_rst        (ch_rst),
    .all_ready     (all_ready),
    .lock_loss_cnt (lock_loss_cnt),
    .timeout_flag  (timeout_flag)
  );

  // vec layout: {timeout_flag, pll_rst, ch_rst[2:0], all_ready, lock_loss_cnt[7:0]}
  typedef struct {
    int          cyc;
    logic [13:0] vec;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  task automatic push(input int c, input logic tf, input logic pr, input logic [2:0] ch,
                      input logic rd, input logic [7:0] ls, input string nm);
    exp_t e;
    e.cyc  = c;
    e.vec  = {tf, pr, ch, rd, ls};
    e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    cpu_reset_n = 1'b0;
    pll_locked  = 1'b0;
    repeat (3) @(negedge clk);
    cpu_reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    logic [13:0] obs;
    cpu_reset_n = 1'b0;
    pll_locked  = 1'b0;
    repeat (3) @(negedge clk);
    obs = {timeout_flag, pll_rst, ch_rst, all_ready, lock_loss_cnt};
    n_cmp++;
    if (obs !== 14'b0_1_111_0_00000000) begin
      n_bad++;
      $display("FAIL reset_state: got %b expected %b", obs, 14'b0_1_111_0_00000000);
    end
    cpu_reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_bringup();
    exp_t e;
    logic [13:0] obs;
    push(0,  0, 1, 3'b111, 0, 0, "bringup_c0");
    push(7,  0, 1, 3'b111, 0, 0, "bringup_rst_last");
    push(8,  0, 0, 3'b111, 0, 0, "bringup_rst_drop");
    push(37, 0, 0, 3'b111, 0, 0, "bringup_pre_rel");
    push(38, 0, 0, 3'b110, 0, 0, "bringup_ch0");
    push(41, 0, 0, 3'b110, 0, 0, "bringup_pre_ch1");
    push(42, 0, 0, 3'b100, 0, 0, "bringup_ch1");
    push(45, 0, 0, 3'b100, 0, 0, "bringup_pre_ch2");
    push(46, 0, 0, 3'b000, 0, 0, "bringup_ch2");
    push(47, 0, 0, 3'b000, 1, 0, "bringup_ready");
    while (cyc <= 47) begin
      while (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        e = sb_q.pop_front();
        obs = {timeout_flag, pll_rst, ch_rst, all_ready, lock_loss_cnt};
        n_cmp++;
        if (obs !== e.vec) begin
          n_bad++;
          $display("FAIL %s cyc=%0d: got %b expected %b", e.name, cyc, obs, e.vec);
        end
      end
      if (cyc == 20) pll_locked = 1'b1;
      tick();
    end
  endtask

  task automatic test_glitch_stable();
    exp_t e;
    logic [13:0] obs;
    do_reset();
    push(8,  0, 0, 3'b111, 0, 0, "glitch_wait");
    push(39, 0, 0, 3'b111, 0, 0, "glitch_requalify");
    push(40, 0, 0, 3'b110, 0, 0, "glitch_ch0");
    push(48, 0, 0, 3'b000, 0, 0, "glitch_ch2");
    push(49, 0, 0, 3'b000, 1, 0, "glitch_ready");
    while (cyc <= 49) begin
      while (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        e = sb_q.pop_front();
        obs = {timeout_flag, pll_rst, ch_rst, all_ready, lock_loss_cnt};
        n_cmp++;
        if (obs !== e.vec) begin
          n_bad++;
          $display("FAIL %s cyc=%0d: got %b expected %b", e.name, cyc, obs, e.vec);
        end
      end
      if (cyc == 0)  pll_locked = 1'b1;
      if (cyc == 19) pll_locked = 1'b0;
      if (cyc == 22) pll_locked = 1'b1;
      tick();
    end
  endtask

  task automatic test_lock_loss_run();
    exp_t e;
    logic [13:0] obs;
    push(57, 0, 0, 3'b000, 1, 0, "loss_still_run");
    push(58, 0, 1, 3'b111, 0, 1, "loss_abort");
    push(65, 0, 1, 3'b111, 0, 1, "loss_rst_last");
    push(66, 0, 0, 3'b111, 0, 1, "loss_rst_drop");
    push(81, 0, 0, 3'b111, 0, 1, "loss_pre_rel");
    push(82, 0, 0, 3'b110, 0, 1, "loss_ch0");
    push(90, 0, 0, 3'b000, 0, 1, "loss_ch2");
    push(91, 0, 0, 3'b000, 1, 1, "loss_ready");
    while (cyc <= 91) begin
      while (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        e = sb_q.pop_front();
        obs = {timeout_flag, pll_rst, ch_rst, all_ready, lock_loss_cnt};
        n_cmp++;
        if (obs !== e.vec) begin
          n_bad++;
          $display("FAIL %s cyc=%0d: got %b expected %b", e.name, cyc, obs, e.vec);
        end
      end
      if (cyc == 55) pll_locked = 1'b0;
      if (cyc == 56) pll_locked = 1'b1;
      tick();
    end
  endtask

  task automatic test_abort_release();
    exp_t e;
    logic [13:0] obs;
    push(98,  0, 1, 3'b111, 0, 2, "abort_second_loss");
    push(122, 0, 0, 3'b110, 0, 2, "abort_ch0");
    push(125, 0, 0, 3'b110, 0, 2, "abort_partial");
    push(126, 0, 1, 3'b111, 0, 3, "abort_all_rst");
    while (cyc <= 126) begin
      while (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        e = sb_q.pop_front();
        obs = {timeout_flag, pll_rst, ch_rst, all_ready, lock_loss_cnt};
        n_cmp++;
        if (obs !== e.vec) begin
          n_bad++;
          $display("FAIL %s cyc=%0d: got %b expected %b", e.name, cyc, obs, e.vec);
        end
      end
      if (cyc == 95)  pll_locked = 1'b0;
      if (cyc == 96)  pll_locked = 1'b1;
      if (cyc == 123) pll_locked = 1'b0;
      if (cyc == 124) pll_locked = 1'b1;
      tick();
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    logic [13:0] obs;
    push(160, 0, 0, 3'b000, 1, 3, "async_pre_run");
    while (cyc <= 160) begin
      while (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        e = sb_q.pop_front();
        obs = {timeout_flag, pll_rst, ch_rst, all_ready, lock_loss_cnt};
        n_cmp++;
        if (obs !== e.vec) begin
          n_bad++;
          $display("FAIL %s cyc=%0d: got %b expected %b", e.name, cyc, obs, e.vec);
        end
      end
      tick();
    end
    @(posedge clk);
    #2;
    cpu_reset_n = 1'b0;
    #1;
    obs = {timeout_flag, pll_rst, ch_rst, all_ready, lock_loss_cnt};
    n_cmp++;
    if (obs !== 14'b0_1_111_0_00000000) begin
      n_bad++;
      $display("FAIL async_reset: got %b expected %b", obs, 14'b0_1_111_0_00000000);
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    int   waited;
    int   exp_loss;
    logic [13:0] obs;
    do_reset();
    pll_locked = 1'b1;
    for (int ev = 1; ev <= 257; ev++) begin
      waited = 0;
      while (ch_rst[0] !== 1'b0 && waited < 200) begin
        tick();
        waited++;
      end
      if (waited >= 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sat_release_timeout event=%0d: got ch_rst=%b expected release within 200 cycles",
                 ev, ch_rst);
        break;
      end
      exp_loss = (ev > 255) ? 255 : ev;
      push(cyc + 3, 0, 1, 3'b111, 0, 8'(exp_loss), "sat_loss_cnt");
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      tick();
      tick();
      e = sb_q.pop_front();
      obs = {timeout_flag, pll_rst, ch_rst, all_ready, lock_loss_cnt};
      n_cmp++;
      if (obs !== e.vec || cyc != e.cyc) begin
        n_bad++;
        $display("FAIL %s event=%0d cyc=%0d: got %b expected %b", e.name, ev, cyc, obs, e.vec);
      end
    end
  endtask

`ifdef PLL_RESET_SEQUENCER_LOCK_TIMEOUT_EN
  task automatic test_timeout();
    exp_t e;
    logic [13:0] obs;
    do_reset();
    push(1031, 0, 0, 3'b111, 0, 0, "to_before");
    push(1032, 1, 1, 3'b111, 0, 0, "to_repulse");
    push(1039, 1, 1, 3'b111, 0, 0, "to_rst_last");
    push(1040, 1, 0, 3'b111, 0, 0, "to_rst_drop");
    push(1066, 1, 0, 3'b000, 0, 0, "to_ch2");
    push(1067, 1, 0, 3'b000, 1, 0, "to_sticky_run");
    while (cyc <= 1067) begin
      while (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        e = sb_q.pop_front();
        obs = {timeout_flag, pll_rst, ch_rst, all_ready, lock_loss_cnt};
        n_cmp++;
        if (obs !== e.vec) begin
          n_bad++;
          $display("FAIL %s cyc=%0d: got %b expected %b", e.name, cyc, obs, e.vec);
        end
      end
      if (cyc == 1040) pll_locked = 1'b1;
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_bringup();
    test_glitch_stable();
    test_lock_loss_run();
    test_abort_release();
    test_async_reset();
    test_saturate();
`ifdef PLL_RESET_SEQUENCER_LOCK_TIMEOUT_EN
    test_timeout();
`endif
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
